// File: rtl/prbs_checker.sv
// PRBS stream checker: follows the upstream Fibonacci LFSR word stream,
// locks after a run of correct words, then flywheels its own reference so
// each corrupted word is reported exactly once.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SEARCH | reseeding from every received word, counting consecutive hits
// LOCKED | free-running reference, counting and reporting mismatches
module prbs_checker #(
   parameter int unsigned           WIDTH      = 4,
   parameter logic [WIDTH-1:0]      TAPS       = 4'b1100,
   parameter int unsigned           LOCK_COUNT = 4,
   parameter int unsigned           LOSS_COUNT = 3,
   parameter int unsigned           CW         = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             clear_in,
   output logic             locked_out,
   output logic             err_pulse_out,
   output logic [CW-1:0]    err_count_out
);

   localparam int unsigned HW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned LW = $clog2(LOSS_COUNT + 1);
   localparam logic [HW-1:0] HIT_LAST  = HW'(LOCK_COUNT - 1);
   localparam logic [HW-1:0] HIT_FULL  = HW'(LOCK_COUNT);
   localparam logic [LW-1:0] MISS_LAST = LW'(LOSS_COUNT - 1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state;
   logic [WIDTH-1:0] ref_word;
   logic             ref_vld;
   logic [HW-1:0]    hit_run;
   logic [LW-1:0]    miss_run;

   logic [WIDTH-1:0] ref_next;
   logic             match;
   logic [CW-1:0]    cnt_base;

   function automatic logic [WIDTH-1:0] step_word(input logic [WIDTH-1:0] q);
      return {q[WIDTH-2:0], ^(q & TAPS)};
   endfunction

   // Prediction and compare; all-zero is the LFSR lockup word and never counts as a hit.
   always_comb begin
      ref_next = step_word(ref_word);
      match    = (data_in == ref_next) && (data_in != '0);
      cnt_base = clear_in ? '0 : err_count_out;
   end

   // Lock FSM, reference tracking and error accounting.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= SEARCH;
         ref_word      <= '0;
         ref_vld       <= 1'b0;
         hit_run       <= '0;
         miss_run      <= '0;
         err_pulse_out <= 1'b0;
         err_count_out <= '0;
      end else begin
         err_pulse_out <= 1'b0;
         err_count_out <= cnt_base;
         if (valid_in) begin
            if (!ref_vld) begin
               ref_word <= data_in;
               ref_vld  <= 1'b1;
            end else begin
               case (state)
                  SEARCH: begin
                     ref_word <= data_in;
                     if (match) begin
                        if (hit_run == HIT_LAST) begin
                           hit_run  <= HIT_FULL;
                           miss_run <= '0;
                           state    <= LOCKED;
                        end else begin
                           hit_run <= hit_run + 1'b1;
                        end
                     end else begin
                        hit_run <= '0;
                     end
                  end
                  LOCKED: begin
                     ref_word <= ref_next;
                     if (match) begin
                        miss_run <= '0;
                     end else begin
                        err_pulse_out <= 1'b1;
                        err_count_out <= (&cnt_base) ? cnt_base : cnt_base + 1'b1;
                        if (miss_run == MISS_LAST) begin
                           // too many misses in a row: drop lock and reseed from the stream
                           state    <= SEARCH;
                           hit_run  <= '0;
                           miss_run <= '0;
                           ref_word <= data_in;
                        end else begin
                           miss_run <= miss_run + 1'b1;
                        end
                     end
                  end
                  default: state <= SEARCH;
               endcase
            end
         end
      end
   end

   assign locked_out = (state == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default instance plus a CW=2 instance
// sharing the same stimulus so saturation can be observed.
module tb_prbs_checker;

   logic       clk_sys = 1'b0;
   logic       rst     = 1'b0;
   logic       valid   = 1'b0;
   logic [3:0] data    = 4'h0;
   logic       clear   = 1'b0;

   logic       locked, pulse;
   logic [7:0] count;
   logic       locked2, pulse2;
   logic [1:0] count2;

   int n_checks = 0;
   int n_pass   = 0;
   int idx      = 0;
   logic pulse_seen;

   // x^4+x^3+1 sequence from seed 0101, worked out by hand
   logic [3:0] seq [15] = '{4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110,
                            4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100,
                            4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010};

   prbs_checker dut (
      .clk_in(clk_sys), .rst_in(rst), .valid_in(valid), .data_in(data),
      .clear_in(clear), .locked_out(locked), .err_pulse_out(pulse),
      .err_count_out(count)
   );

   prbs_checker #(.CW(2)) dut2 (
      .clk_in(clk_sys), .rst_in(rst), .valid_in(valid), .data_in(data),
      .clear_in(clear), .locked_out(locked2), .err_pulse_out(pulse2),
      .err_count_out(count2)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic step(input logic v, input logic [3:0] d, input logic c);
      @(negedge clk_sys);
      valid = v;
      data  = d;
      clear = c;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_good();
      step(1'b1, seq[idx], 1'b0);
      idx = (idx + 1) % 15;
   endtask

   task automatic send_bad(input logic [3:0] d, input logic c);
      step(1'b1, d, c);
      idx = (idx + 1) % 15;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 4'b1010, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      check("rst_locked", locked, 0);
      check("rst_pulse", pulse, 0);
      check("rst_count", count, 0);

      // clean lock and 30 good words
      pulse_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         send_good();
         pulse_seen |= pulse;
         if (i == 3) check("lock_after_4", locked, 0);
         if (i == 4) check("lock_after_5", locked, 1);
      end
      check("clean_count", count, 0);
      check("clean_pulse", pulse_seen, 0);
      check("clean_locked", locked, 1);

      // single corrupted word 1101 in place of 1100
      for (int i = 0; i < 5; i++) send_good();
      send_bad(4'b1101, 1'b0);
      check("single_pulse", pulse, 1);
      check("single_count", count, 1);
      check("single_count2", count2, 1);
      check("single_locked", locked, 1);
      send_good();
      check("single_pulse_end", pulse, 0);
      check("single_count_hold", count, 1);
      check("single_still_lock", locked, 1);
      for (int i = 0; i < 3; i++) send_good();

      // clear while idle: count zero, lock kept
      step(1'b0, 4'b0000, 1'b1);
      check("clear_count", count, 0);
      check("clear_count2", count2, 0);
      check("clear_locked", locked, 1);

      // three wrong words in a row lose lock
      send_bad(4'b0000, 1'b0);
      check("loss1_count", count, 1);
      check("loss1_locked", locked, 1);
      send_bad(4'b0000, 1'b0);
      check("loss2_count", count, 2);
      check("loss2_locked", locked, 1);
      send_bad(4'b1111, 1'b0);
      check("loss3_count", count, 3);
      check("loss3_pulse", pulse, 1);
      check("loss3_locked", locked, 0);

      // relock: one reseed word plus four matches
      send_good();
      check("relock_reseed_count", count, 3);
      for (int i = 0; i < 3; i++) send_good();
      check("relock_not_yet", locked, 0);
      send_good();
      check("relock_done", locked, 1);

      // reset while locked
      do_reset();
      check("midrst_locked", locked, 0);
      check("midrst_count", count, 0);

      // valid-gapped stream, idle cycles carry garbage data
      for (int i = 0; i < 5; i++) begin
         send_good();
         if (i == 3) check("gap_lock_after_4", locked, 0);
         if (i == 4) check("gap_lock_after_5", locked, 1);
         step(1'b0, 4'b0000, 1'b0);
         check("gap_idle_pulse", pulse, 0);
      end
      check("gap_idle_locked", locked, 1);
      check("gap_count", count, 0);

      // clear coincident with an error leaves count at 1
      send_bad(seq[idx] ^ 4'b0001, 1'b0);
      check("clr_pre_count", count, 1);
      send_bad(seq[idx] ^ 4'b0001, 1'b1);
      check("clr_err_count", count, 1);
      check("clr_err_count2", count2, 1);
      check("clr_err_pulse", pulse, 1);
      send_good();
      check("clr_locked", locked, 1);

      // saturation of the 2-bit counter, pulses continue
      for (int i = 0; i < 4; i++) begin
         send_bad(seq[idx] ^ 4'b0010, 1'b0);
         check("sat_pulse2", pulse2, 1);
         send_good();
      end
      check("sat_count", count, 5);
      check("sat_count2", count2, 3);
      check("sat_locked", locked, 1);

      // all-zero stream never locks and never counts
      do_reset();
      pulse_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'b0000, 1'b0);
         pulse_seen |= pulse;
      end
      check("zero_locked", locked, 0);
      check("zero_count", count, 0);
      check("zero_pulse", pulse_seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Sits directly downstream of the team's Fibonacci LFSR generator and consumes its parallel output word every valid cycle.
- Predicts each next word from the previous one and locks onto the sequence after a run of consecutive correct words.
- Once locked, it free-runs its own generator, so an isolated corrupted word counts as exactly one error.
- Reports lock status, a per-word error pulse and a saturating error count; used for on-board link/BIST checking of PRBS streams.

Parameters:
- WIDTH, 4, LFSR word width N; must be at least 2.
- TAPS, 4'b1100, feedback mask; must match the upstream generator. Default is x^4+x^3+1, period 15.
- LOCK_COUNT, 4, consecutive matches needed to enter LOCKED; must be at least 1.
- LOSS_COUNT, 3, consecutive mismatches in LOCKED that force a return to SEARCH; must be at least 1.
- CW, 8, error counter width.

Ports:
- clk_in  input  1  system clock; the block uses one clock only.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in is a new LFSR word this cycle.
- data_in  input  WIDTH  received LFSR word.
- clear_in  input  1  synchronous clear of err_count_out.
- locked_out  output  1  checker is in the LOCKED state.
- err_pulse_out  output  1  one-cycle pulse: the previous valid word mismatched while LOCKED.
- err_count_out  output  CW  saturating count of LOCKED mismatches.

Behaviour:
- Step function: next(q) = {q[WIDTH-2:0], ^(q & TAPS)}.
- Registers:
  - ref: last reference word.
  - ref_vld: ref holds a word.
  - state: SEARCH or LOCKED.
  - hit_run: 0..LOCK_COUNT.
  - miss_run: 0..LOSS_COUNT.
- Reset (rst_in=1 at clk edge):
  - state=SEARCH, ref=0, ref_vld=0, hit_run=0, miss_run=0.
  - locked_out=0, err_pulse_out=0, err_count_out=0.
  - Reset mid-operation discards lock immediately.
- Match rule: match = (data_in == next(ref)) && (data_in != 0). The all-zero word is always a mismatch (lockup state).
- valid_in=0: all state holds; err_pulse_out=0 on the next cycle.
- valid_in=1 and ref_vld=0: ref<=data_in, ref_vld<=1; no compare, no counters change.
- SEARCH, valid_in=1, ref_vld=1:
  - ref<=data_in, so the checker reseeds from the stream.
  - On match: hit_run++. If hit_run reaches LOCK_COUNT, state<=LOCKED, miss_run<=0.
  - On mismatch: hit_run<=0.
  - Errors are never counted in SEARCH.
- LOCKED, valid_in=1:
  - ref<=next(ref) regardless of data_in (flywheel).
  - On match: miss_run<=0.
  - On mismatch: err_pulse_out=1 on the next cycle; err_count_out increments, saturating at 2^CW-1; miss_run++.
  - If miss_run reaches LOSS_COUNT: state<=SEARCH, hit_run<=0, ref<=data_in (reseed).
- locked_out is the registered state, so it rises the cycle after the LOCK_COUNT-th match.
- Latency: err_pulse_out and err_count_out update one cycle after the offending valid word.
- clear_in:
  - Zeroes err_count_out on the next edge.
  - If an error occurs in the same cycle, the count becomes 1 (clear, then increment).
  - clear_in does not affect lock state or err_pulse_out.
- Simultaneous reset and any other input: reset wins.
- Saturation: at the max count, further errors still pulse err_pulse_out but the count holds.

Test Plan:
- Reset, then feed seed 0101 and successors 1011,0111,1111,1110,... one per cycle with valid_in=1 -> locked_out=1 the cycle after the 5th word (4 matches); err_count_out=0 over 30 words.
- While locked, replace one word (expected 1100) with 1101, then resume the correct sequence -> exactly one err_pulse_out, err_count_out=1, locked_out stays 1.
- While locked, feed 3 consecutive wrong words -> err_count_out=3, locked_out falls after the 3rd; resume a correct stream -> relock after 1+4 words.
- Valid-gapped stream (valid_in toggling 1/0) with the correct sequence -> lock after 5 valid words; idle cycles change nothing.
- Feed 0000 repeatedly -> never locks; err_count_out=0. Force CW=2 and 5 locked errors -> err_count_out saturates at 3. Pulse clear_in coincident with an error -> err_count_out=1.
- Assert rst_in for one cycle while locked -> next cycle locked_out=0, err_count_out=0; needs 5 fresh valid words to relock.
